counter_prescaled: RTL and testbench
====================================

Name: counter_prescaled

Overview:
Parametrised successor to the fixed-divider LED counter. It has a run-time programmable prescaler and a programmable modulo limit. It supports three count modes (wrap, saturate, one-shot), synchronous load, and registered tick/terminal-count/done status. It sits between board-level controls (switches and buttons) and display or timing logic, and is reusable as a general event timer.

Parameters:
WIDTH, 4, width of cnt_val, limit and load_val.
DIV_W, 27, width of the prescaler counter and div_val (27 bits covers 100 M at 100 MHz).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
enable  in  1  1 = prescaler and counter advance; 0 = everything holds
dir  in  1  0 = count up, 1 = count down
mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap)
div_val  in  DIV_W  prescaler period minus 1; one step per div_val+1 enabled cycles
limit  in  WIDTH  top of count range; cnt_val spans 0..limit
load  in  1  synchronous load strobe
load_val  in  WIDTH  value to load
cnt_val  out  WIDTH  current count (registered)
tick  out  1  registered pulse, one cycle per prescaler step
tc  out  1  registered pulse on a step taken at the terminal value
done  out  1  sticky one-shot completion flag

Behaviour:
- Reset (reset=0, asynchronous): div_cnt=0, cnt_val=0, tick=0, tc=0, done=0. Release is synchronous to clk.
- Prescaler:
  - step = enable & (div_cnt >= div_val).
  - On step, div_cnt <= 0. Otherwise, if enable=1, div_cnt <= div_cnt+1.
  - Using >= means that shrinking div_val mid-count causes a step on the next enabled cycle, with no run-off to 2^DIV_W.
  - div_val=0 gives a step on every enabled cycle.
- tick <= step. tick goes high in the same cycle the updated cnt_val becomes visible, i.e. one cycle after the step edge condition.
- Terminal value: limit when dir=0, 0 when dir=1. Up-count treats cnt_val >= limit as terminal; this covers the case where limit is lowered below cnt_val.
- Count update on step, when done=0 or mode!=one-shot:
  - Non-terminal: cnt_val +1 (up) or -1 (down).
  - Terminal, wrap: up goes to 0, down goes to limit; tc <= 1.
  - Terminal, saturate: cnt_val holds; tc <= 1 on every step taken at terminal.
  - Terminal, one-shot: cnt_val holds; tc <= 1; done <= 1. While done=1, further steps still produce tick, but cnt_val holds and tc=0.
- tc is 0 on every cycle without a terminal step.
- Load has priority over step:
  - cnt_val <= min(load_val, limit).
  - div_cnt <= 0, done <= 0, tc <= 0, tick <= 0.
- enable=0 (no load): div_cnt and cnt_val hold; tick=0, tc=0.
- Changes to dir, mode or limit take effect on the next step. No pipeline flush is needed.
- All arithmetic is unsigned, modulo 2^WIDTH internally. There is no overflow beyond limit.
- limit=0: every step is terminal; cnt_val stays at 0.

Decomposition:
- Package counter_pkg:
  - typedef enum logic [1:0] mode_t {MODE_WRAP, MODE_SAT, MODE_ONESHOT, MODE_RSVD}.
  - Default DIV_W constant.
- Sub-module counter_prescaler (params DIV_W; ports clk, reset, enable, clr, div_val, step). It is reusable by other timing blocks. clr is driven by load.
- The top holds the count/mode logic and output registers.

Test Plan:
- Reset held 0 with enable=1 for 5 cycles -> cnt_val=0, tick=tc=done=0; release -> first tick after div_val+1 enabled cycles.
- WIDTH=4, div_val=2, limit=9, mode wrap, dir=0, 40 cycles -> tick every 3 cycles; cnt_val 0..9 then 0; tc=1 exactly on the 9->0 step. With dir=1 from 0 -> goes to 9 with tc=1.
- mode saturate, dir=0, limit=5, div_val=0 -> cnt_val reaches 5 and holds; tc=1 on every following step; dir=1 -> counts down to 0 and holds.
- mode one-shot, load_val=3, dir=1, div_val=1 -> 3,2,1,0; tc single pulse; done=1 and stays; further ticks leave cnt_val=0. Load 7 -> done=0 and counting resumes.
- Load and step in the same cycle (load_val=12, limit=10) -> cnt_val=10, tick=0, prescaler restarts from 0.
- div_cnt=20 with div_val=50, div_val changed to 5 -> step on the next enabled cycle. enable=0 for 10 cycles -> no tick, cnt_val unchanged.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and defaults for the prescaled counter family.
// Pure declarations; no logic, no latency, no flow control.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_t;

  localparam int DIV_W_DEF = 27;
  localparam int WIDTH_DEF = 4;

endpackage

// File: rtl/counter_prescaler.sv
// Programmable prescaler: step fires once per div_val+1 enabled cycles.
// Latency: step is combinational from the registered div_cnt; no backpressure, holds when enable=0.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clr,
  input  logic [DIV_W-1:0] div_val,
  output logic             step
);

  logic [DIV_W-1:0] div_cnt;

  // >= so that shrinking div_val mid-period steps immediately rather than running off to 2^DIV_W
  assign step = enable & (div_cnt >= div_val);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (clr || step) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/counter_prescaled.sv
// Prescaled modulo counter with wrap/saturate/one-shot modes and synchronous load.
// Latency: cnt_val/tick/tc/done update one cycle after the step edge; no backpressure, load wins over step.
module counter_prescaled
  import counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt_val,
  output logic             tick,
  output logic             tc,
  output logic             done
);

  logic             step;
  logic             at_term;
  logic             frozen;
  logic [WIDTH-1:0] load_clamped;
  mode_t            mode_q;

  counter_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .clr     (load),
    .div_val (div_val),
    .step    (step)
  );

  assign mode_q = mode_t'(mode);

  // Up-count uses >= so a limit lowered below cnt_val still terminates cleanly
  assign at_term      = dir ? (cnt_val == '0) : (cnt_val >= limit);
  assign frozen       = (mode_q == MODE_ONESHOT) && done;
  assign load_clamped = (load_val > limit) ? limit : load_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_val <= '0;
      tick    <= 1'b0;
      tc      <= 1'b0;
      done    <= 1'b0;
    end else if (load) begin
      cnt_val <= load_clamped;
      tick    <= 1'b0;
      tc      <= 1'b0;
      done    <= 1'b0;
    end else begin
      tick <= step;
      tc   <= 1'b0;
      if (step && !frozen) begin
        if (!at_term) begin
          cnt_val <= dir ? (cnt_val - WIDTH'(1)) : (cnt_val + WIDTH'(1));
        end else begin
          tc <= 1'b1;
          case (mode_q)
            MODE_SAT:     cnt_val <= cnt_val;
            MODE_ONESHOT: done    <= 1'b1;
            default:      cnt_val <= dir ? limit : '0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_prescaled.sv
// Directed bench for counter_prescaled: reset, wrap, saturate, one-shot, load priority, prescaler retiming.
module tb_counter_prescaled;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        dir;
  logic [1:0]  mode;
  logic [26:0] div_val;
  logic [3:0]  limit;
  logic        load;
  logic [3:0]  load_val;
  logic [3:0]  cnt_val;
  logic        tick;
  logic        tc;
  logic        done;

  int checks = 0;
  int errors = 0;

  counter_prescaled #(.WIDTH(4), .DIV_W(27)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .dir      (dir),
    .mode     (mode),
    .div_val  (div_val),
    .limit    (limit),
    .load     (load),
    .load_val (load_val),
    .cnt_val  (cnt_val),
    .tick     (tick),
    .tc       (tc),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Clean start: load a value for one cycle, which also clears the prescaler and done.
  task automatic do_load(input logic [3:0] v);
    load     = 1'b1;
    load_val = v;
    cyc();
    load     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; dir = 1'b0; mode = 2'b00;
    div_val = 27'd2; limit = 4'd9; load = 1'b0; load_val = 4'd0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if ({cnt_val, tick, tc, done} !== 7'b0000_000) begin
        $display("FAIL reset_hold cyc%0d: {cnt,tick,tc,done}=%b expected 0000000", i, {cnt_val, tick, tc, done});
        errors++;
      end
    end
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      checks++;
      if (tick !== (i == 3) || cnt_val !== ((i == 3) ? 4'd1 : 4'd0)) begin
        $display("FAIL reset_release cyc%0d: tick=%b cnt=%0d expected tick=%b cnt=%0d",
                 i, tick, cnt_val, (i == 3), (i == 3) ? 1 : 0);
        errors++;
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_cnt;
    logic       exp_tc;
    int         tc_seen;
    mode = 2'b00; dir = 1'b0; limit = 4'd9; div_val = 27'd2;
    do_load(4'd0);
    exp_cnt = 4'd0;
    tc_seen = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      exp_tc = 1'b0;
      if (i % 3 == 0) begin
        if (exp_cnt == 4'd9) begin
          exp_cnt = 4'd0;
          exp_tc  = 1'b1;
        end else begin
          exp_cnt = exp_cnt + 4'd1;
        end
      end
      if (tc) tc_seen++;
      checks++;
      if (cnt_val !== exp_cnt || tick !== (i % 3 == 0) || tc !== exp_tc) begin
        $display("FAIL wrap_up cyc%0d: cnt=%0d tick=%b tc=%b expected cnt=%0d tick=%b tc=%b",
                 i, cnt_val, tick, tc, exp_cnt, (i % 3 == 0), exp_tc);
        errors++;
      end
    end
    checks++;
    if (tc_seen != 1) begin
      $display("FAIL wrap_tc_count: got %0d tc pulses expected 1", tc_seen);
      errors++;
    end
    // Down from 0 wraps to limit with a terminal pulse
    dir = 1'b1; div_val = 27'd0;
    do_load(4'd0);
    cyc();
    checks++;
    if (cnt_val !== 4'd9 || tc !== 1'b1 || tick !== 1'b1) begin
      $display("FAIL wrap_down_0: cnt=%0d tc=%b tick=%b expected cnt=9 tc=1 tick=1", cnt_val, tc, tick);
      errors++;
    end
    cyc();
    checks++;
    if (cnt_val !== 4'd8 || tc !== 1'b0) begin
      $display("FAIL wrap_down_1: cnt=%0d tc=%b expected cnt=8 tc=0", cnt_val, tc);
      errors++;
    end
  endtask

  task automatic test_saturate();
    mode = 2'b01; dir = 1'b0; limit = 4'd5; div_val = 27'd0;
    do_load(4'd0);
    for (int i = 1; i <= 8; i++) begin
      cyc();
      checks++;
      if (cnt_val !== ((i < 5) ? 4'(i) : 4'd5) || tc !== (i >= 6) || tick !== 1'b1) begin
        $display("FAIL sat_up cyc%0d: cnt=%0d tc=%b tick=%b expected cnt=%0d tc=%b tick=1",
                 i, cnt_val, tc, tick, (i < 5) ? i : 5, (i >= 6));
        errors++;
      end
    end
    dir = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      cyc();
      checks++;
      if (cnt_val !== ((i <= 5) ? 4'(5 - i) : 4'd0) || tc !== (i >= 6)) begin
        $display("FAIL sat_down cyc%0d: cnt=%0d tc=%b expected cnt=%0d tc=%b",
                 i, cnt_val, tc, (i <= 5) ? 5 - i : 0, (i >= 6));
        errors++;
      end
    end
  endtask

  task automatic test_oneshot();
    logic [3:0] exp_cnt;
    mode = 2'b10; dir = 1'b1; limit = 4'd9; div_val = 27'd1;
    do_load(4'd3);
    checks++;
    if (cnt_val !== 4'd3 || done !== 1'b0 || tick !== 1'b0) begin
      $display("FAIL os_load: cnt=%0d done=%b tick=%b expected cnt=3 done=0 tick=0", cnt_val, done, tick);
      errors++;
    end
    for (int i = 1; i <= 12; i++) begin
      cyc();
      exp_cnt = (i >= 6) ? 4'd0 : 4'(3 - i / 2);
      checks++;
      if (cnt_val !== exp_cnt || tick !== (i % 2 == 0) || tc !== (i == 8) || done !== (i >= 8)) begin
        $display("FAIL oneshot cyc%0d: cnt=%0d tick=%b tc=%b done=%b expected cnt=%0d tick=%b tc=%b done=%b",
                 i, cnt_val, tick, tc, done, exp_cnt, (i % 2 == 0), (i == 8), (i >= 8));
        errors++;
      end
    end
    do_load(4'd7);
    checks++;
    if (cnt_val !== 4'd7 || done !== 1'b0) begin
      $display("FAIL os_reload: cnt=%0d done=%b expected cnt=7 done=0", cnt_val, done);
      errors++;
    end
    cyc();
    cyc();
    checks++;
    if (cnt_val !== 4'd6 || tick !== 1'b1 || done !== 1'b0) begin
      $display("FAIL os_resume: cnt=%0d tick=%b done=%b expected cnt=6 tick=1 done=0", cnt_val, tick, done);
      errors++;
    end
  endtask

  task automatic test_load_step();
    mode = 2'b00; dir = 1'b0; limit = 4'd10; div_val = 27'd3;
    do_load(4'd0);
    cyc(); cyc(); cyc();
    // Prescaler now at its period end: load must win over the step
    do_load(4'd12);
    checks++;
    if (cnt_val !== 4'd10 || tick !== 1'b0 || tc !== 1'b0) begin
      $display("FAIL load_vs_step: cnt=%0d tick=%b tc=%b expected cnt=10 tick=0 tc=0", cnt_val, tick, tc);
      errors++;
    end
    for (int i = 1; i <= 4; i++) begin
      cyc();
      checks++;
      if (tick !== (i == 4) || cnt_val !== ((i == 4) ? 4'd0 : 4'd10) || tc !== (i == 4)) begin
        $display("FAIL load_restart cyc%0d: tick=%b cnt=%0d tc=%b expected tick=%b cnt=%0d tc=%b",
                 i, tick, cnt_val, tc, (i == 4), (i == 4) ? 0 : 10, (i == 4));
        errors++;
      end
    end
  endtask

  task automatic test_div_shrink_enable();
    mode = 2'b00; dir = 1'b0; limit = 4'd15; div_val = 27'd50;
    do_load(4'd0);
    for (int i = 1; i <= 20; i++) begin
      cyc();
      checks++;
      if (tick !== 1'b0) begin
        $display("FAIL slow_div cyc%0d: tick=%b expected 0", i, tick);
        errors++;
      end
    end
    div_val = 27'd5;
    cyc();
    checks++;
    if (tick !== 1'b1 || cnt_val !== 4'd1) begin
      $display("FAIL div_shrink: tick=%b cnt=%0d expected tick=1 cnt=1", tick, cnt_val);
      errors++;
    end
    cyc(); cyc();
    enable = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      checks++;
      if (tick !== 1'b0 || tc !== 1'b0 || cnt_val !== 4'd1) begin
        $display("FAIL enable_low cyc%0d: tick=%b tc=%b cnt=%0d expected tick=0 tc=0 cnt=1", i, tick, tc, cnt_val);
        errors++;
      end
    end
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      checks++;
      if (tick !== (i == 4) || cnt_val !== ((i == 4) ? 4'd2 : 4'd1)) begin
        $display("FAIL enable_resume cyc%0d: tick=%b cnt=%0d expected tick=%b cnt=%0d",
                 i, tick, cnt_val, (i == 4), (i == 4) ? 2 : 1);
        errors++;
      end
    end
  endtask

  task automatic test_limit_edges();
    mode = 2'b00; dir = 1'b0; limit = 4'd15; div_val = 27'd0;
    do_load(4'd10);
    // Limit lowered below the count: next up-step is terminal and wraps to 0
    limit = 4'd4;
    cyc();
    checks++;
    if (cnt_val !== 4'd0 || tc !== 1'b1) begin
      $display("FAIL limit_lowered: cnt=%0d tc=%b expected cnt=0 tc=1", cnt_val, tc);
      errors++;
    end
    limit = 4'd0; mode = 2'b11; dir = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      checks++;
      if (cnt_val !== 4'd0 || tc !== 1'b1 || tick !== 1'b1) begin
        $display("FAIL limit_zero cyc%0d: cnt=%0d tc=%b tick=%b expected cnt=0 tc=1 tick=1", i, cnt_val, tc, tick);
        errors++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_saturate();
    test_oneshot();
    test_load_step();
    test_div_shrink_enable();
    test_limit_edges();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
